// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-side program counter sequencer.
package pc_sequencer_pkg;

  localparam logic [1:0] PC_CTRL_HOLD = 2'b00;
  localparam logic [1:0] PC_CTRL_PUB  = 2'b01;
  localparam logic [1:0] PC_CTRL_LOAD = 2'b10;

  localparam int          DEF_PC_INCR  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BOOT,
    S_PUBLISH,
    S_SETTLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_UPDATE,
    S_HALTED
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC selection and alignment check; standalone so a
// branch predictor can reuse it later.
module pc_next_calc #(
  parameter int PC_W    = 32,
  parameter int PC_INCR = 4
) (
  input  logic [PC_W-1:0] cur_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] check_pc,
  output logic [PC_W-1:0] nxt,
  output logic            misaligned
);

  localparam logic [PC_W-1:0] INCR       = PC_W'(PC_INCR);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(PC_INCR - 1);

  // The sequential path wraps naturally modulo 2^PC_W.
  assign nxt        = br_taken ? br_target : cur_pc + INCR;
  assign misaligned = |(check_pc & ALIGN_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: boots/loads/publishes the program counter, fetches over
// req/ack, issues to execute and loads the next PC from the execute result.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              PC_INCR  = DEF_PC_INCR,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic [PC_W-1:0]    pc_value,
  output logic [1:0]         pc_ctrl,
  output logic [PC_W-1:0]    pc_next,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               exec_done,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               fault,
  output logic [31:0]        retired
);

  seq_state_t      state_reg, state_next;
  logic [PC_W-1:0] cur_pc_reg;
  logic [PC_W-1:0] nxt;
  logic            misaligned;
  logic            set_fault;
  logic [1:0]      ctrl_next;

  pc_next_calc #(
    .PC_W    (PC_W),
    .PC_INCR (PC_INCR)
  ) u_next_calc (
    .cur_pc     (cur_pc_reg),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .check_pc   (pc_value),
    .nxt        (nxt),
    .misaligned (misaligned)
  );

  always_comb begin
    state_next = state_reg;
    set_fault  = 1'b0;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_BOOT;
      S_BOOT:    state_next = S_PUBLISH;
      S_PUBLISH: state_next = S_SETTLE;
      S_SETTLE: begin
        // pc_value is checked directly since cur_pc is only captured on this edge.
        if (halt_req) begin
          state_next = S_HALTED;
        end else if (misaligned) begin
          state_next = S_HALTED;
          set_fault  = 1'b1;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_FETCH:   if (imem_ack) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_EXEC;
      S_EXEC:    if (exec_done) state_next = S_UPDATE;
      S_UPDATE:  state_next = S_PUBLISH;
      S_HALTED:  if (start && !fault) state_next = S_PUBLISH;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ctrl_next = PC_CTRL_HOLD;
    case (state_next)
      S_BOOT, S_UPDATE: ctrl_next = PC_CTRL_LOAD;
      S_PUBLISH:        ctrl_next = PC_CTRL_PUB;
      default:          ctrl_next = PC_CTRL_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cur_pc_reg  <= '0;
      pc_ctrl     <= PC_CTRL_HOLD;
      pc_next     <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      fault       <= 1'b0;
      retired     <= '0;
    end else begin
      state_reg   <= state_next;
      pc_ctrl     <= ctrl_next;
      imem_req    <= (state_next == S_FETCH);
      instr_valid <= (state_next == S_ISSUE);
      if (state_reg == S_IDLE && state_next == S_BOOT) begin
        pc_next <= RESET_PC;
      end
      if (state_reg == S_SETTLE) begin
        cur_pc_reg <= pc_value;
        imem_addr  <= pc_value;
      end
      if (state_reg == S_FETCH && imem_ack) begin
        instr <= imem_data;
      end
      if (state_reg == S_EXEC && exec_done) begin
        pc_next <= nxt;
        retired <= retired + 32'd1;
      end
      if (set_fault) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instruction vectors drive a
// memory/execute model; a monitor compares loads, fetch addresses and issues.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] pc_value = '0;
  logic [1:0]  pc_ctrl;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        exec_done = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        fault;
  logic [31:0] retired;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .pc_value    (pc_value),
    .pc_ctrl     (pc_ctrl),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .exec_done   (exec_done),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fault       (fault),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Program counter model: loads on 10, exposes its value on 01.
  logic [31:0] pc_reg_m = '0;
  always @(posedge clk) begin
    if (pc_ctrl == PC_CTRL_LOAD)     pc_reg_m <= pc_next;
    else if (pc_ctrl == PC_CTRL_PUB) pc_value <= pc_reg_m;
  end

  typedef struct {
    int          delay;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
    logic        halt;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] load_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          ret_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic        prev_req;
    logic [31:0] prev_addr;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pc_ctrl == 2'b11) begin
          n_vec++;
          n_miss++;
          $display("FAIL pc_ctrl_illegal: got 11 expected 00/01/10");
        end
        if (pc_ctrl == PC_CTRL_LOAD) begin
          if (load_q.size() == 0) check("unexpected_load", pc_next, 32'hxxxx_xxxx);
          else check("pc_next", pc_next, load_q.pop_front());
        end
        if (imem_req && prev_req) check("addr_stable", imem_addr, prev_addr);
        if (imem_req && imem_ack) begin
          if (addr_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
          else check("imem_addr", imem_addr, addr_q.pop_front());
        end
        if (instr_valid) begin
          if (instr_q.size() == 0) check("unexpected_issue", instr, 32'hxxxx_xxxx);
          else check("instr", instr, instr_q.pop_front());
        end
        prev_req  = imem_req;
        prev_addr = imem_addr;
      end else begin
        prev_req = 1'b0;
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    addr_q.push_back(v.exp_addr);
    instr_q.push_back(v.data);
    load_q.push_back(v.exp_next);
    wait_req(ok);
    check("req_seen", {31'b0, ok}, 32'd1);
    if (!ok) return;
    for (int i = 0; i < v.delay; i++) begin
      check("req_held", {31'b0, imem_req}, 32'd1);
      tick();
    end
    imem_ack  = 1'b1;
    imem_data = v.data;
    tick();
    imem_ack  = 1'b0;
    imem_data = '0;
    check("req_drop", {31'b0, imem_req}, 32'd0);
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    tick();
    check("valid_one_cycle", {31'b0, instr_valid}, 32'd0);
    exec_done = 1'b1;
    br_taken  = v.taken;
    br_target = v.target;
    if (v.halt) halt_req = 1'b1;
    tick();
    exec_done = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    ret_exp++;
    check("retired", retired, ret_exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc_ctrl"}, {30'b0, pc_ctrl}, 32'd0);
    check({tag, "_pc_next"}, pc_next, 32'd0);
    check({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_fault"}, {31'b0, fault}, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    int ctrl_act;
    //          delay data          tk    target         halt  addr           next
    vecs[0] = '{0, 32'h1111_0001, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{0, 32'h2222_0002, 1'b0, 32'h0,          1'b0, 32'h0000_0004, 32'h0000_0008};
    vecs[2] = '{5, 32'h3333_0003, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 32'h0000_000C};
    vecs[3] = '{1, 32'h4444_0004, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_000C, 32'h0000_0100};
    vecs[4] = '{0, 32'h5555_0005, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0100, 32'hFFFF_FFFC};
    vecs[5] = '{2, 32'h6666_0006, 1'b0, 32'h0,          1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[6] = '{0, 32'h7777_0007, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0004};
    vecs[7] = '{0, 32'h8888_0008, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0004, 32'h0000_0102};

    fork
      monitor();
    join_none

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    load_q.push_back(32'h0);  // boot load of RESET_PC
    pulse_start();
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Halt raised during execute: next PC still loads, then no further fetch.
    run_vec(vecs[6]);
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req) reqs++;
    end
    check("halt_no_req", reqs, 0);
    check("halt_ctrl_hold", {30'b0, pc_ctrl}, 32'd0);
    check("halt_no_fault", {31'b0, fault}, 32'd0);
    halt_req = 1'b0;
    pulse_start();

    // Resume fetches the loaded PC, then a misaligned branch faults.
    run_vec(vecs[7]);
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req) reqs++;
    end
    check("fault_no_req", reqs, 0);
    check("fault_set", {31'b0, fault}, 32'd1);
    pulse_start();
    reqs = 0;
    ctrl_act = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req) reqs++;
      if (pc_ctrl != PC_CTRL_HOLD) ctrl_act++;
    end
    check("fault_start_ignored_req", reqs, 0);
    check("fault_start_ignored_ctrl", ctrl_act, 0);
    check("fault_sticky", {31'b0, fault}, 32'd1);
    check("retired_total", retired, 32'd8);

    // Reset in the middle of a fetch, then a stale ack.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    load_q.push_back(32'h0);
    pulse_start();
    begin
      bit ok;
      wait_req(ok);
      check("reset_fetch_req", {31'b0, ok}, 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    rst = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack  = 1'b0;
    imem_data = '0;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req || instr_valid) reqs++;
      tick();
    end
    check("stale_ack_ignored", reqs, 0);
    check("stale_ack_instr", instr, 32'd0);

    check("load_q_empty", load_q.size(), 32'd0);
    check("addr_q_empty", addr_q.size(), 32'd0);
    check("instr_q_empty", instr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that drives the program counter's 2-bit control/load interface, which the program counter only consumes. Issues per cycle: publish (01) to expose the current PC, load (10) to write a new PC, hold (00) otherwise. It fetches the instruction at the published address over a req/ack memory handshake, hands the instruction to execute, then computes and loads the next PC from the execute result (sequential or taken branch).

Parameters:
PC_W, 32, PC and address width.
INSTR_W, 32, instruction width.
PC_INCR, 4, sequential increment in bytes.
RESET_PC, 0, PC value loaded by the boot load after start.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  one-cycle pulse; leaves IDLE/HALTED.
halt_req  in  1  level; stop at next instruction boundary.
pc_value  in  PC_W  program counter's published output.
pc_ctrl  out  2  00 hold, 01 publish, 10 load; 11 never driven.
pc_next  out  PC_W  value to load; meaningful only when pc_ctrl=10.
imem_req  out  1  fetch request; held until imem_ack.
imem_addr  out  PC_W  fetch address; stable while imem_req=1.
imem_ack  in  1  one-cycle; imem_data valid same cycle.
imem_data  in  INSTR_W  fetched instruction.
instr_valid  out  1  one-cycle pulse; instr is valid.
instr  out  INSTR_W  registered instruction.
exec_done  in  1  one-cycle pulse; execute finished the current instruction.
br_taken  in  1  sampled with exec_done.
br_target  in  PC_W  absolute target; sampled with exec_done when br_taken=1.
fault  out  1  sticky; misaligned PC target.
retired  out  32  count of completed instructions; wraps at 2^32.

Behaviour:
- Reset (rst=0, async): state=IDLE; pc_ctrl=00, pc_next=0, imem_req=0, imem_addr=0, instr_valid=0, instr=0, fault=0, retired=0. All outputs are registered.
- FSM states: IDLE, BOOT, PUBLISH, SETTLE, FETCH, ISSUE, EXEC, UPDATE, HALTED.
- IDLE: on start go to BOOT.
- BOOT (1 cycle): pc_ctrl=10, pc_next=RESET_PC, then go to PUBLISH.
- PUBLISH (1 cycle): pc_ctrl=01, then go to SETTLE.
- SETTLE (1 cycle): pc_ctrl=00. The program counter updates its output on the PUBLISH edge, so pc_value is valid here. Capture pc_value into the internal cur_pc register.
- SETTLE exits:
  - If halt_req=1, go to HALTED.
  - Else if cur_pc is not PC_INCR-aligned (low log2(PC_INCR) bits nonzero), set fault=1 and go to HALTED.
  - Else go to FETCH with imem_req=1 and imem_addr=cur_pc.
- FETCH: hold imem_req/imem_addr until imem_ack. On the ack cycle: latch imem_data into instr, drop imem_req, go to ISSUE.
- ISSUE (1 cycle): instr_valid=1, then go to EXEC.
- EXEC: wait for exec_done. On exec_done:
  - nxt = br_taken ? br_target : cur_pc + PC_INCR, mod 2^PC_W; wrap from all-ones is legal.
  - retired += 1.
  - Go to UPDATE.
- UPDATE (1 cycle): pc_ctrl=10, pc_next=nxt, then go to PUBLISH.
- Steady-state loop: UPDATE, PUBLISH, SETTLE, FETCH, ISSUE, EXEC. Minimum 6 cycles per instruction with zero-wait memory (ack in the first FETCH cycle) and exec_done in the first EXEC cycle.
- HALTED: pc_ctrl=00 and imem_req=0.
  - start with fault=0 resumes at PUBLISH; the PC register keeps its value.
  - start with fault=1 is ignored. Only reset clears fault.
- halt_req is sampled only in SETTLE. An in-flight fetch or execute always completes, and the next PC is always loaded before halting.
- exec_done outside EXEC is ignored. imem_ack outside FETCH is ignored.
- start outside IDLE/HALTED is ignored.
- Reset mid-FETCH: imem_req deasserts immediately (async). A later stale imem_ack is ignored because the state is not FETCH.
- pc_ctrl=11 is never driven.

Decomposition:
- Shared package:
  - PC_CTRL_HOLD=2'b00, PC_CTRL_PUB=2'b01, PC_CTRL_LOAD=2'b10.
  - State enum typedef.
  - Default PC_INCR/RESET_PC constants.
- One natural sub-module: pc_next_calc. Combinational next-PC mux, adder and alignment check, kept separate so it can be reused by a future branch predictor.

Test Plan:
1. Reset then start, zero-wait memory, exec_done with br_taken=0 three times:
   - pc_ctrl sequence is 10(pc_next=0), 01, 00, …, 10(pc_next=4).
   - imem_addr = 0, 4, 8.
   - retired=3.
2. Fetch at PC=8, imem_ack delayed 5 cycles:
   - imem_req held high 6 cycles with imem_addr=8 stable.
   - instr_valid pulses once, one cycle after ack, with instr = the acked data.
3. Branch taken: exec_done with br_taken=1, br_target=0x100:
   - next UPDATE drives pc_next=0x100.
   - next imem_addr=0x100.
4. Misaligned branch: br_target=0x102:
   - load 0x102 happens, then fault=1 in SETTLE, state HALTED, no imem_req.
   - A following start pulse is ignored.
5. Wrap: RESET_PC=0xFFFFFFFC, not taken:
   - pc_next=0x00000000 and no fault.
6. Halt and reset during fetch:
   - halt_req asserted during EXEC: the instruction completes, UPDATE loads the next PC, halt occurs at SETTLE; start then resumes at the loaded PC.
   - rst=0 mid-FETCH: all outputs are zero in the same cycle.
